// File: rtl/systolic_feeder_if.sv
// Tile-offer channel into the systolic feeder: one tile per valid/ready handshake.
interface systolic_feeder_if #(
    parameter int ACT_WIDTH = 16,
    parameter int N         = 2,
    parameter int W_MAX     = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [N*ACT_WIDTH-1:0] act_data;
    logic [N*W_MAX-1:0]     w_data;
    logic [3:0]             precision_in;

    modport master (output in_valid, act_data, w_data, precision_in, input in_ready);
    modport slave  (input in_valid, act_data, w_data, precision_in, output in_ready);
endinterface

// File: rtl/systolic_feeder.sv
// Feeds one tile into the FP-INT systolic array: bit-serial skewed weights down the
// columns, skewed activations on the rows, then waits for the array to finish.
module systolic_feeder #(
    parameter int ACT_WIDTH = 16,
    parameter int N         = 2,
    parameter int W_MAX     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_feeder_if.slave       tile,
    input  logic                   array_done,
    output logic [N*ACT_WIDTH-1:0] act_out,
    output logic [N-1:0]           w_out,
    output logic                   active,
    output logic [3:0]             precision_out,
    output logic                   tile_done
);
    localparam int CW = $clog2(W_MAX + N);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT} state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [N*ACT_WIDTH-1:0] act_reg;
    logic [N*W_MAX-1:0]     w_reg;
    logic [3:0]             p_clamped;
    logic                   last;

    always_comb begin
        p_clamped = tile.precision_in;
        if (tile.precision_in == 4'd0)
            p_clamped = 4'd1;
        else if (tile.precision_in > 4'(W_MAX))
            p_clamped = 4'(W_MAX);
    end

    always_comb last = (32'(cnt) == 32'(precision_out) + 32'(N) - 32'd2);

    // Column j carries bit (c-j) of its weight while 0 <= c-j < P.
    function automatic logic [N-1:0] stream_w(input logic [N*W_MAX-1:0] w,
                                              input logic [3:0] p, input int unsigned c);
        logic [W_MAX-1:0] col;
        stream_w = '0;
        for (int unsigned j = 0; j < N; j++) begin
            col = w[j*W_MAX +: W_MAX];
            if (c >= j && (c - j) < 32'(p)) begin
                col = col >> (c - j);
                stream_w[j] = col[0];
            end
        end
    endfunction

    function automatic logic [N*ACT_WIDTH-1:0] stream_act(input logic [N*ACT_WIDTH-1:0] a,
                                                          input logic [3:0] p, input int unsigned c);
        stream_act = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (c >= i && c < i + 32'(p))
                stream_act[i*ACT_WIDTH +: ACT_WIDTH] = a[i*ACT_WIDTH +: ACT_WIDTH];
        end
    endfunction

    // Outputs are computed for the count the next cycle will show, so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            act_reg       <= '0;
            w_reg         <= '0;
            tile.in_ready <= 1'b1;
            active        <= 1'b0;
            tile_done     <= 1'b0;
            w_out         <= '0;
            act_out       <= '0;
            precision_out <= '0;
        end else begin
            tile_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tile.in_valid) begin
                        state         <= STREAM;
                        cnt           <= '0;
                        act_reg       <= tile.act_data;
                        w_reg         <= tile.w_data;
                        precision_out <= p_clamped;
                        tile.in_ready <= 1'b0;
                        active        <= 1'b1;
                        w_out         <= stream_w(tile.w_data, p_clamped, 0);
                        act_out       <= stream_act(tile.act_data, p_clamped, 0);
                    end
                end
                STREAM: begin
                    if (last) begin
                        state   <= WAIT;
                        active  <= 1'b0;
                        w_out   <= '0;
                        act_out <= '0;
                    end else begin
                        cnt     <= cnt + 1'b1;
                        w_out   <= stream_w(w_reg, precision_out, 32'(cnt) + 32'd1);
                        act_out <= stream_act(act_reg, precision_out, 32'(cnt) + 32'd1);
                    end
                end
                WAIT: begin
                    if (array_done) begin
                        state         <= IDLE;
                        tile_done     <= 1'b1;
                        tile.in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: driver queues expected stream beats, a
// negedge monitor pops one per active cycle and counts tile_done pulses.
module tb_systolic_feeder;
    logic        clk = 1'b0;
    logic        rst;
    logic        array_done;
    logic [31:0] act_out;
    logic [1:0]  w_out;
    logic        active;
    logic [3:0]  precision_out;
    logic        tile_done;

    systolic_feeder_if #(.ACT_WIDTH(16), .N(2), .W_MAX(8)) bus ();

    systolic_feeder #(.ACT_WIDTH(16), .N(2), .W_MAX(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .tile          (bus),
        .array_done    (array_done),
        .act_out       (act_out),
        .w_out         (w_out),
        .active        (active),
        .precision_out (precision_out),
        .tile_done     (tile_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  w;
        logic [31:0] act;
        logic [3:0]  prec;
    } exp_t;

    exp_t sq[$];
    int   errors    = 0;
    int   checks    = 0;
    int   done_exp  = 0;
    int   done_seen = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Two-column reference written straight from the skew rules.
    function automatic exp_t model(input logic [15:0] a0, input logic [15:0] a1,
                                   input logic [7:0] w0, input logic [7:0] w1,
                                   input int p, input int c);
        exp_t e;
        e.prec = 4'(p);
        e.w    = 2'b00;
        e.act  = 32'h0;
        if (c >= 0 && c < p)         e.w[0] = w0[c];
        if (c - 1 >= 0 && c - 1 < p) e.w[1] = w1[c-1];
        if (c >= 0 && c < p)         e.act[15:0]  = a0;
        if (c >= 1 && c < p + 1)     e.act[31:16] = a1;
        return e;
    endfunction

    task automatic push_tile(input logic [15:0] a0, input logic [15:0] a1,
                             input logic [7:0] w0, input logic [7:0] w1,
                             input int p, input int count);
        for (int c = 0; c < count; c++) sq.push_back(model(a0, a1, w0, w1, p, c));
    endtask

    task automatic push_hand(input logic [1:0] w, input logic [31:0] act, input logic [3:0] prec);
        exp_t e;
        e.w = w; e.act = act; e.prec = prec;
        sq.push_back(e);
    endtask

    task automatic offer(input logic [15:0] a0, input logic [15:0] a1,
                         input logic [7:0] w0, input logic [7:0] w1, input logic [3:0] pin);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) chk("ready_timeout", 32'(bus.in_ready), 32'h1);
        bus.act_data     = {a1, a0};
        bus.w_data       = {w1, w0};
        bus.precision_in = pin;
        bus.in_valid     = 1'b1;
        @(negedge clk);
        bus.in_valid     = 1'b0;
    endtask

    task automatic wait_fall;
        int n = 0;
        while (active === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("fall_timeout", 32'(active), 32'h0);
        chk("stream_len", sq.size(), 0);
    endtask

    task automatic wait_done(input int delay);
        for (int k = 0; k < delay; k++) begin
            chk("wait_active", 32'(active), 32'h0);
            chk("wait_ready", 32'(bus.in_ready), 32'h0);
            @(negedge clk);
        end
        array_done = 1'b1;
        done_exp++;
        @(negedge clk);
        chk("done_ready", 32'(bus.in_ready), 32'h1);
        chk("done_pulse", 32'(tile_done), 32'h1);
        array_done = 1'b0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (active === 1'b1) begin
                if (sq.size() == 0) begin
                    chk("stream_extra", 32'(active), 32'h0);
                end else begin
                    e = sq.pop_front();
                    chk("w_out", 32'(w_out), 32'(e.w));
                    chk("act_out", act_out, e.act);
                    chk("precision_out", 32'(precision_out), 32'(e.prec));
                end
            end
            if (tile_done === 1'b1) begin
                chk("tile_done_extra", 32'(done_seen < done_exp), 32'h1);
                done_seen++;
            end
        end
    end

    initial begin
        rst              = 1'b1;
        array_done       = 1'b0;
        bus.in_valid     = 1'b0;
        bus.act_data     = '0;
        bus.w_data       = '0;
        bus.precision_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 32'(bus.in_ready), 32'h1);
            chk("rst_active", 32'(active), 32'h0);
            chk("rst_w_out", 32'(w_out), 32'h0);
            chk("rst_act_out", act_out, 32'h0);
            chk("rst_tile_done", 32'(tile_done), 32'h0);
            chk("rst_precision", 32'(precision_out), 32'h0);
            @(negedge clk);
        end

        // Tile A, hand-computed: w0=1011 w1=0110, P=4.
        push_hand(2'b01, 32'h0000_3C00, 4'd4);
        push_hand(2'b01, 32'h4000_3C00, 4'd4);
        push_hand(2'b10, 32'h4000_3C00, 4'd4);
        push_hand(2'b11, 32'h4000_3C00, 4'd4);
        push_hand(2'b00, 32'h4000_0000, 4'd4);
        offer(16'h3C00, 16'h4000, 8'b0000_1011, 8'b0000_0110, 4'd4);
        for (int n = 0; active === 1'b1 && n < 40; n++) begin
            bus.in_valid     = 1'b1;
            bus.act_data     = $urandom;
            bus.w_data       = 16'($urandom);
            bus.precision_in = 4'($urandom);
            @(negedge clk);
        end
        chk("a_fall", 32'(active), 32'h0);
        chk("a_stream_len", sq.size(), 0);

        // Tile B offered during WAIT; accepted back-to-back with A's tile_done.
        bus.act_data     = {16'h2222, 16'h1111};
        bus.w_data       = {8'hFE, 8'hFF};
        bus.precision_in = 4'd0;
        push_tile(16'h1111, 16'h2222, 8'hFF, 8'hFE, 1, 2);
        wait_done(3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_fall();
        chk("b_precision", 32'(precision_out), 32'd1);
        wait_done(0);

        // Tile E: precision 15 clamps to 8.
        push_tile(16'h7BFF, 16'hC000, 8'hA5, 8'h3C, 8, 9);
        offer(16'h7BFF, 16'hC000, 8'hA5, 8'h3C, 4'd15);
        wait_fall();
        chk("e_precision", 32'(precision_out), 32'd8);
        wait_done(1);

        // Tile C: reset on c=2 drops it.
        push_tile(16'hABCD, 16'h1234, 8'hF5, 8'h9A, 4, 3);
        offer(16'hABCD, 16'h1234, 8'hF5, 8'h9A, 4'd4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'h1);
        chk("mid_rst_active", 32'(active), 32'h0);
        chk("mid_rst_w_out", 32'(w_out), 32'h0);
        chk("mid_rst_act_out", act_out, 32'h0);
        chk("mid_rst_precision", 32'(precision_out), 32'h0);
        chk("mid_rst_tile_done", 32'(tile_done), 32'h0);
        chk("mid_rst_consumed", sq.size(), 0);
        rst = 1'b0;
        @(negedge clk);

        // Tile D: P=3, upper weight bits must be ignored.
        push_tile(16'h5555, 16'hAAAA, 8'hFF, 8'h07, 3, 4);
        offer(16'h5555, 16'hAAAA, 8'hFF, 8'h07, 4'd3);
        wait_fall();
        wait_done(0);

        repeat (3) @(negedge clk);
        chk("done_count", done_seen, done_exp);
        chk("queue_empty", sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Transmit-side front end for the FP-INT systolic MAC array. Accepts one tile per handshake: N activations, N multi-bit integer weights and a precision. Streams the weights bit-serially, LSB first, down the N column inputs, and holds the activations on the N row inputs, with one-cycle skew per column/row. Raises the array's `active` for the whole stream window, then waits for the array's `done` before accepting the next tile.

## Interface

Parameters:
- `ACT_WIDTH`, 16, activation word width (FP16)
- `N`, 2, array dimension (rows = columns)
- `W_MAX`, 8, maximum weight bit-width; weight inputs are `W_MAX` bits each

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `in_valid`  in  1  tile offered
- `in_ready`  out  1  feeder can accept a tile
- `act_data`  in  N*ACT_WIDTH  row activations; row i = bits [i*ACT_WIDTH +: ACT_WIDTH]
- `w_data`  in  N*W_MAX  column weights; column j = bits [j*W_MAX +: W_MAX]
- `precision_in`  in  4  weight bit-width for this tile
- `array_done`  in  1  completion flag from the array
- `act_out`  out  N*ACT_WIDTH  per-row activation to the array
- `w_out`  out  N  per-column serial weight bit to the array
- `active`  out  1  array enable
- `precision_out`  out  4  effective precision latched for the current tile
- `tile_done`  out  1  one-cycle pulse when the tile completes

## Operation

- Effective precision P:
  - P = `precision_in` clamped to the range 1..`W_MAX`.
  - 0 maps to 1; values above `W_MAX` map to `W_MAX`.
  - Latched at accept and driven on `precision_out` until the next accept.
- Accept occurs on a cycle with `in_valid` & `in_ready`.
  - `act_data`, `w_data` and P are captured into internal registers.
  - Weight bits at positions ≥ P are ignored.
- States and transitions:
  - IDLE: `in_ready`=1. Accept → STREAM with count c=0.
  - STREAM: `in_ready`=0, `active`=1.
    - c increments each cycle.
    - When c = P+N-2 → WAIT.
  - WAIT: `active`=0, `in_ready`=0.
    - On `array_done`=1 → IDLE, with `tile_done`=1 for that one transition cycle.
- Stream content, in the STREAM cycle with count c:
  - `w_out[j]` = bit (c−j) of weight j if 0 ≤ c−j < P, else 0.
  - `act_out` row i = activation i if i ≤ c < i+P, else 0.
- Outside STREAM, `act_out` = 0 and `w_out` = 0.
- STREAM length is exactly P+N−1 cycles.
- `array_done` is ignored in IDLE and STREAM.
- `in_valid` is ignored outside IDLE; no tile is queued.
- Counter width: ceil(log2(W_MAX+N)) bits; no wrap within a tile.

## Timing

- All outputs are registered.
- Reset values: `in_ready`=1, `active`=0, `tile_done`=0, `w_out`=0, `act_out`=0, `precision_out`=0. State = IDLE, c=0.
- Accept at edge E → first STREAM cycle (c=0) is visible after E. There are no bubble cycles.
- Stream to done:
  - `active` falls in the first WAIT cycle.
  - `array_done` sampled at edge F → `tile_done`=1 and `in_ready`=1 in the cycle after F.
  - A new accept is possible on that same cycle.
- Minimum tile period: P+N+1 cycles (accept, STREAM, one WAIT cycle with `array_done` already high).
- `array_done` high on the first WAIT cycle completes the tile immediately.
- `rst` asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - The in-flight tile is dropped and no `tile_done` is produced.
- Simultaneous `rst` and `in_valid`: reset wins, no accept.

## Test plan

- Reset, then hold 3 cycles → `in_ready`=1, `active`=0, `w_out`=00, `act_out`=0, `tile_done`=0 every cycle.
- N=2, P=4, w0=0b1011, w1=0b0110, act0=0x3C00, act1=0x4000, accept → 5 STREAM cycles with `active`=1:
  - `w_out[0]` = 1,1,0,1,0
  - `w_out[1]` = 0,0,1,1,0
  - row0 = 3C00,3C00,3C00,3C00,0000
  - row1 = 0000,4000,4000,4000,4000
- Same tile, `array_done` raised 3 cycles into WAIT → `active`=0 throughout WAIT; single `tile_done` pulse; `in_ready` returns the same cycle; second tile accepted back-to-back.
- `precision_in`=0 → P=1, STREAM 2 cycles, `precision_out`=1. `precision_in`=15 with `W_MAX`=8 → P=8, STREAM 9 cycles, `precision_out`=8.
- `in_valid` held high during STREAM/WAIT with changing data → no effect on the current stream; next tile accepted only in IDLE.
- `rst` asserted on c=2 of STREAM → next cycle IDLE, outputs zero, no `tile_done`; a fresh tile then streams correctly from c=0.
